riscv_wb_stage: RTL and testbench

Write-back stage that consumes the EX→WB handshake: it accepts load instructions leaving EX, waits for the data memory response, then aligns and sign/zero-extends the load data and drives the register-file write port. It produces wb_ready, which gates EX completion. It sits between the EX stage, the LSU data response, and register-file write port B.

---
 rtl/riscv_wb_stage.sv | 190 +++++++++++++++++++
 tb/tb_riscv_wb_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_wb_stage.sv
// riscv_wb_stage: load write-back stage.
//
// Accepts load instructions from EX over the ex_valid_i / wb_ready_o handshake.
// Waits for the data-memory response, then aligns and extends the load data
// and drives register-file write port B. If the response carries a bus error,
// the stage raises a one-cycle error pulse instead of writing.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ex_valid_i          EX hands an instruction to WB this cycle
//   regfile_we_i        the instruction is a load that needs a write
//   regfile_waddr_i     destination register
//   lsu_type_i          00 word, 01 half, 10 byte, 11 treated as word
//   lsu_sign_ext_i      1 = sign-extend, 0 = zero-extend
//   lsu_addr_lsb_i      load address bits [1:0]
//   data_rvalid_i       memory response valid
//   data_rdata_i        raw memory read word
//   data_err_i          bus error, qualified by data_rvalid_i
//   wb_ready_o          WB can accept an instruction this cycle
//   wb_busy_o           a load write is outstanding (ID hazard stall)
//   regfile_we_o/waddr_o/wdata_o   register-file write port
//   load_err_o, load_err_waddr_o   one-cycle pulse on an erroneous response
//
// Build option:
//   RISCV_WB_REG_OUT_EN  when defined, the write port and the error outputs are
//                        registered and appear one cycle after the response.
//                        wb_busy_o stays high through that extra cycle.

module riscv_wb_stage #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ex_valid_i,
  input  logic                      regfile_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] regfile_waddr_i,
  input  logic [1:0]                lsu_type_i,
  input  logic                      lsu_sign_ext_i,
  input  logic [1:0]                lsu_addr_lsb_i,
  input  logic                      data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  input  logic                      data_err_i,
  output logic                      wb_ready_o,
  output logic                      wb_busy_o,
  output logic                      regfile_we_o,
  output logic [REG_ADDR_WIDTH-1:0] regfile_waddr_o,
  output logic [DATA_WIDTH-1:0]     regfile_wdata_o,
  output logic                      load_err_o,
  output logic [REG_ADDR_WIDTH-1:0] load_err_waddr_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [1:0] LT_HALF = 2'b01;
  localparam logic [1:0] LT_BYTE = 2'b10;

  logic [0:0]                state;
  logic [0:0]                state_nxt;
  logic [REG_ADDR_WIDTH-1:0] waddr_p0;
  logic [1:0]                ld_type_p0;
  logic                      sign_p0;
  logic [1:0]                lsb_p0;

  logic                      done;
  logic                      ready;
  logic                      accept;
  logic                      wr_en;
  logic                      err;
  logic [DATA_WIDTH-1:0]     wdata_c;
  logic [REG_ADDR_WIDTH-1:0] waddr_c;
  logic [REG_ADDR_WIDTH-1:0] err_waddr_c;

  // Select the addressed lane and extend it to the full word. Word and the
  // reserved type pass the response through; misaligned words never arrive.
  function automatic logic [DATA_WIDTH-1:0] extract_load(
    input logic [1:0]            ld_type,
    input logic                  sign_ext,
    input logic [1:0]            lsb,
    input logic [DATA_WIDTH-1:0] rdata
  );
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    logic [DATA_WIDTH-1:0] res;
    half_v = lsb[1] ? rdata[31:16] : rdata[15:0];
    case (lsb)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    case (ld_type)
      LT_HALF: res = {{16{sign_ext & half_v[15]}}, half_v};
      LT_BYTE: res = {{24{sign_ext & byte_v[7]}}, byte_v};
      default: res = rdata;
    endcase
    return res;
  endfunction

  // A response only counts while a load is outstanding; one in IDLE is dropped.
  assign done   = (state == ST_WAIT) & data_rvalid_i;
  assign ready  = (state == ST_IDLE) | done;
  // ex_valid_i while not ready is ignored here rather than captured.
  assign accept = ex_valid_i & regfile_we_i & ready;

  assign wr_en  = done & ~data_err_i;
  assign err    = done & data_err_i;

  // Outputs are held at zero outside their pulse so the write port is quiet.
  assign wdata_c     = wr_en ? extract_load(ld_type_p0, sign_p0, lsb_p0, data_rdata_i)
                             : '0;
  assign waddr_c     = wr_en ? waddr_p0 : '0;
  assign err_waddr_c = err   ? waddr_p0 : '0;

  // A new capture wins over completion so back-to-back loads stay in WAIT.
  always_comb begin
    state_nxt = state;
    if (accept)
      state_nxt = ST_WAIT;
    else if (done)
      state_nxt = ST_IDLE;
  end

  // p0: capture of the accepted load's attributes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      waddr_p0   <= '0;
      ld_type_p0 <= '0;
      sign_p0    <= 1'b0;
      lsb_p0     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        waddr_p0   <= regfile_waddr_i;
        ld_type_p0 <= lsu_type_i;
        sign_p0    <= lsu_sign_ext_i;
        lsb_p0     <= lsu_addr_lsb_i;
      end
    end
  end

  assign wb_ready_o = ready;

`ifdef RISCV_WB_REG_OUT_EN
  logic                      vld_p1;
  logic                      we_p1;
  logic [REG_ADDR_WIDTH-1:0] waddr_p1;
  logic [DATA_WIDTH-1:0]     wdata_p1;
  logic                      err_p1;
  logic [REG_ADDR_WIDTH-1:0] err_waddr_p1;

  // p1: registered write port, one cycle after the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      we_p1        <= 1'b0;
      waddr_p1     <= '0;
      wdata_p1     <= '0;
      err_p1       <= 1'b0;
      err_waddr_p1 <= '0;
    end else begin
      vld_p1       <= done;
      we_p1        <= wr_en;
      waddr_p1     <= waddr_c;
      wdata_p1     <= wdata_c;
      err_p1       <= err;
      err_waddr_p1 <= err_waddr_c;
    end
  end

  // The registered write has not reached the register file yet, so ID must
  // keep stalling for that cycle too.
  assign wb_busy_o        = (state == ST_WAIT) | vld_p1;
  assign regfile_we_o     = we_p1;
  assign regfile_waddr_o  = waddr_p1;
  assign regfile_wdata_o  = wdata_p1;
  assign load_err_o       = err_p1;
  assign load_err_waddr_o = err_waddr_p1;
`else
  assign wb_busy_o        = (state == ST_WAIT);
  assign regfile_we_o     = wr_en;
  assign regfile_waddr_o  = waddr_c;
  assign regfile_wdata_o  = wdata_c;
  assign load_err_o       = err;
  assign load_err_waddr_o = err_waddr_c;
`endif

endmodule

// File: tb/tb_riscv_wb_stage.sv
// tb_riscv_wb_stage: self-checking bench for riscv_wb_stage.
// Directed loads from the test plan followed by randomized traffic, all
// checked every cycle against a queue-based reference model. Build with
// +define+RISCV_WB_REG_OUT_EN to check the registered-output variant.

module tb_riscv_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        regfile_we_i = 1'b0;
  logic [4:0]  regfile_waddr_i = '0;
  logic [1:0]  lsu_type_i = '0;
  logic        lsu_sign_ext_i = 1'b0;
  logic [1:0]  lsu_addr_lsb_i = '0;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        data_err_i = 1'b0;
  logic        wb_ready_o;
  logic        wb_busy_o;
  logic        regfile_we_o;
  logic [4:0]  regfile_waddr_o;
  logic [31:0] regfile_wdata_o;
  logic        load_err_o;
  logic [4:0]  load_err_waddr_o;

  riscv_wb_stage #(.REG_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid_i       (ex_valid_i),
    .regfile_we_i     (regfile_we_i),
    .regfile_waddr_i  (regfile_waddr_i),
    .lsu_type_i       (lsu_type_i),
    .lsu_sign_ext_i   (lsu_sign_ext_i),
    .lsu_addr_lsb_i   (lsu_addr_lsb_i),
    .data_rvalid_i    (data_rvalid_i),
    .data_rdata_i     (data_rdata_i),
    .data_err_i       (data_err_i),
    .wb_ready_o       (wb_ready_o),
    .wb_busy_o        (wb_busy_o),
    .regfile_we_o     (regfile_we_o),
    .regfile_waddr_o  (regfile_waddr_o),
    .regfile_wdata_o  (regfile_wdata_o),
    .load_err_o       (load_err_o),
    .load_err_waddr_o (load_err_waddr_o)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miscompares = 0;
  int writes_seen = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // EX must never offer an instruction while WB is not ready.
  always @(negedge clk) begin
    if (rst_n) assert (!(ex_valid_i && !wb_ready_o));
  end

  // Reference model: outstanding loads kept as records in a queue.
  typedef struct {
    logic [4:0] waddr;
    logic [1:0] ltype;
    logic       sign;
    logic [1:0] lsb;
  } load_t;

  load_t ld_q[$];

  // Previous-cycle results, used as expectations in the registered variant.
  logic        d_done = 1'b0;
  logic        d_we = 1'b0;
  logic [4:0]  d_waddr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_err = 1'b0;
  logic [4:0]  d_ewaddr = '0;

  function automatic logic [31:0] ref_extract(input load_t ld, input logic [31:0] rd);
    int width;
    int shift;
    logic [31:0] v;
    logic [31:0] m;
    case (ld.ltype)
      2'b01:   begin width = 16; shift = 16 * int'(ld.lsb[1]); end
      2'b10:   begin width = 8;  shift = 8 * int'(ld.lsb); end
      default: begin width = 32; shift = 0; end
    endcase
    v = rd >> shift;
    if (width < 32) begin
      m = (32'd1 << width) - 32'd1;
      v = v & m;
      if (ld.sign && v[width-1]) v = v | ~m;
    end
    return v;
  endfunction

  // One clock cycle: drive just after the rising edge, check on the falling
  // edge, then advance the model. ex_valid is withheld if the model says the
  // stage would not be ready, so the bench itself obeys the handshake.
  task automatic cycle(input logic exv, input logic rwe, input logic [4:0] wa,
                       input logic [1:0] ty, input logic sg, input logic [1:0] lsb,
                       input logic rv, input logic [31:0] rd, input logic er);
    logic        m_ready, m_done, m_we, m_err, exv_eff;
    logic [4:0]  m_waddr, m_ewaddr;
    logic [31:0] m_wdata;
    load_t       nl;
    @(posedge clk);
    #1;
    m_ready = (ld_q.size() == 0) || rv;
    exv_eff = exv && m_ready;
    ex_valid_i = exv_eff; regfile_we_i = rwe; regfile_waddr_i = wa;
    lsu_type_i = ty; lsu_sign_ext_i = sg; lsu_addr_lsb_i = lsb;
    data_rvalid_i = rv; data_rdata_i = rd; data_err_i = er;

    m_done   = (ld_q.size() != 0) && rv;
    m_we     = m_done && !er;
    m_err    = m_done && er;
    m_waddr  = m_we  ? ld_q[0].waddr : 5'd0;
    m_ewaddr = m_err ? ld_q[0].waddr : 5'd0;
    m_wdata  = m_we  ? ref_extract(ld_q[0], rd) : 32'd0;

    @(negedge clk);
    check_val("ready", {31'd0, wb_ready_o}, {31'd0, m_ready});
`ifdef RISCV_WB_REG_OUT_EN
    check_val("busy", {31'd0, wb_busy_o}, {31'd0, (ld_q.size() != 0) || d_done});
    check_val("we", {31'd0, regfile_we_o}, {31'd0, d_we});
    check_val("waddr", {27'd0, regfile_waddr_o}, {27'd0, d_waddr});
    check_val("wdata", regfile_wdata_o, d_wdata);
    check_val("err", {31'd0, load_err_o}, {31'd0, d_err});
    check_val("err_waddr", {27'd0, load_err_waddr_o}, {27'd0, d_ewaddr});
    if (d_we) writes_seen++;
`else
    check_val("busy", {31'd0, wb_busy_o}, {31'd0, ld_q.size() != 0});
    check_val("we", {31'd0, regfile_we_o}, {31'd0, m_we});
    check_val("waddr", {27'd0, regfile_waddr_o}, {27'd0, m_waddr});
    check_val("wdata", regfile_wdata_o, m_wdata);
    check_val("err", {31'd0, load_err_o}, {31'd0, m_err});
    check_val("err_waddr", {27'd0, load_err_waddr_o}, {27'd0, m_ewaddr});
    if (m_we) writes_seen++;
`endif

    d_done = m_done; d_we = m_we; d_waddr = m_waddr; d_wdata = m_wdata;
    d_err = m_err; d_ewaddr = m_ewaddr;
    if (m_done) void'(ld_q.pop_front());
    if (exv_eff && rwe) begin
      nl.waddr = wa; nl.ltype = ty; nl.sign = sg; nl.lsb = lsb;
      ld_q.push_back(nl);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic load(input logic [4:0] wa, input logic [1:0] ty, input logic sg, input logic [1:0] lsb);
    cycle(1'b1, 1'b1, wa, ty, sg, lsb, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic resp(input logic [31:0] rd, input logic er);
    cycle(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 2'd0, 1'b1, rd, er);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ex_valid_i = 1'b0; regfile_we_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0;
    #1;
    check_val("rst_ready", {31'd0, wb_ready_o}, 32'd1);
    check_val("rst_busy", {31'd0, wb_busy_o}, 32'd0);
    check_val("rst_we", {31'd0, regfile_we_o}, 32'd0);
    check_val("rst_wdata", regfile_wdata_o, 32'd0);
    check_val("rst_err", {31'd0, load_err_o}, 32'd0);
    ld_q.delete();
    d_done = 1'b0; d_we = 1'b0; d_waddr = '0; d_wdata = '0; d_err = 1'b0; d_ewaddr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int w0;
    do_reset();
    idle(2);

    // byte load, lane 2, sign-extended: expect 0xFFFFFF85 into x5
    w0 = writes_seen;
    load(5'd5, 2'b10, 1'b1, 2'd2);
    idle(1);
    resp(32'h1285_3456, 1'b0);
    idle(2);
    check_val("byte_write_count", writes_seen - w0, 32'd1);

    // halfwords: upper zero-extended, lower sign-extended
    load(5'd7, 2'b01, 1'b0, 2'd2);
    resp(32'h8001_1234, 1'b0);
    load(5'd7, 2'b01, 1'b1, 2'd0);
    resp(32'h0000_F234, 1'b0);
    idle(2);

    // back-to-back: x3 accepted in the response cycle of x4
    load(5'd4, 2'b00, 1'b0, 2'd0);
    idle(1);
    w0 = writes_seen;
    cycle(1'b1, 1'b1, 5'd3, 2'b00, 1'b0, 2'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    resp(32'h0BAD_F00D, 1'b0);
    idle(2);
    check_val("b2b_write_count", writes_seen - w0, 32'd2);

    // bus error on x9: no write, error pulse only
    load(5'd9, 2'b00, 1'b0, 2'd0);
    resp(32'h1111_2222, 1'b1);
    idle(2);

    // non-load, spurious response, then reset while waiting
    cycle(1'b1, 1'b0, 5'd12, 2'b00, 1'b0, 2'd0, 1'b0, 32'd0, 1'b0);
    resp(32'hFFFF_FFFF, 1'b0);
    load(5'd2, 2'b10, 1'b1, 2'd1);
    idle(1);
    do_reset();
    resp(32'h5555_AAAA, 1'b0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic rv;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        rv = (ld_q.size() != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 5'($urandom),
              2'($urandom), 1'($urandom), 2'($urandom), rv, $urandom,
              1'($urandom_range(0, 5) == 0));
      end
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
